chamber_pressure_ctrl: RTL and testbench
========================================

// Module: chamber_pressure_ctrl
// PURPOSE
//   Airlock chamber pressure sequencer, directly upstream of the outer/inner port
//   controllers. Takes the operator evacuate/pressurize switches and the port-open
//   interlock. Runs a timed evacuate or pressurize cycle and produces EVState, which
//   the port stages consume to decide which door may open. Busy is also consumed.
// PARAMETERS
//   EVAC_CYCLES   8   clock cycles spent in EVACUATING (>=2)
//   PRESS_CYCLES  5   clock cycles spent in PRESSURIZING (>=2)
//   CNT_W         8   progress counter width; must hold max(EVAC,PRESS)_CYCLES-1
// PORTS
//   Clock        in   1      system clock, all state on rising edge
//   Reset        in   1      asynchronous, active-low reset
//   EvacSw       in   1      evacuate switch level (asynchronous to Clock)
//   PressSw      in   1      pressurize switch level (asynchronous to Clock)
//   PortOpen     in   1      1 = any chamber port open (from port stages)
//   EVState      out  1      1 = chamber evacuated (state EVACUATED only)
//   Pressurized  out  1      1 = chamber at atmosphere (state PRESSURIZED only)
//   Busy         out  1      1 = EVACUATING or PRESSURIZING
//   Hold         out  1      1 = transition paused by PortOpen
//   Progress     out  CNT_W  cycles elapsed in current transition; 0 otherwise
// BEHAVIOUR
//   Reset (Reset=0, async): state=PRESSURIZED, counter=0, sync/edge flops=0.
//     Outputs: EVState=0, Pressurized=1, Busy=0, Hold=0, Progress=0.
//     Reset asserted mid-transition aborts immediately to PRESSURIZED.
//   Input path: EvacSw/PressSw each pass through a 2-FF synchronizer. A rising-edge
//     detector follows it (pulse = sync2 & ~prev, one cycle wide).
//     Switch change set up before edge N gives a state change at edge N+2.
//   States: PRESSURIZED, EVACUATING, EVACUATED, PRESSURIZING (all outputs registered/
//     decoded from state, no combinational path from inputs to outputs).
//   PRESSURIZED  + evac pulse & ~PortOpen & ~press pulse -> EVACUATING, cnt<=0
//   EVACUATED    + press pulse & ~PortOpen & ~evac pulse -> PRESSURIZING, cnt<=0
//   EVACUATING:  PortOpen=1 -> hold cnt, Hold=1; else cnt++.
//     Leaves to EVACUATED when cnt==EVAC_CYCLES-1 and PortOpen=0.
//     Unpaused dwell is exactly EVAC_CYCLES cycles.
//   PRESSURIZING: same rule with PRESS_CYCLES -> PRESSURIZED.
//   Ignored requests, no state change:
//     - requests while PortOpen=1
//     - simultaneous evac+press pulses
//     - a request for the state already held
//     - any request during a transition (no reversal or abort)
//   Held switch levels never retrigger; a fresh rising edge is required.
//   Progress = cnt in Busy states, 0 elsewhere; cnt never wraps (terminal compare).
//   EVState and Pressurized are never both 1. Both are 0 whenever Busy=1.
// TESTING (defaults EVAC_CYCLES=8, PRESS_CYCLES=5)
//   Reset low mid-run -> EVState=0, Pressurized=1, Busy=0, Progress=0 immediately.
//   EvacSw 0->1, PortOpen=0 -> Busy at +2 edges, Progress 0..7, then EVState=1
//     exactly 8 cycles later; Busy=0.
//   From EVACUATED, PressSw 0->1 -> 5 cycles PRESSURIZING -> Pressurized=1, EVState=0.
//   PortOpen=1 for 3 cycles at Progress=4 during evac -> Hold=1, Progress frozen at 4.
//     EVState arrives 3 cycles late (11 total).
//   EvacSw with PortOpen=1, and EvacSw+PressSw rising together -> no state change.
//   EvacSw held high after EVACUATED, PressSw toggled mid-evac -> both ignored,
//     no retrigger.

Source files
------------

// File: rtl/chamber_pressure_ctrl.sv
// Airlock chamber pressure sequencer: synchronizes the operator switches, detects
// fresh rising edges and runs timed evacuate/pressurize cycles gated by PortOpen.
module chamber_pressure_ctrl #(
  parameter int EVAC_CYCLES  = 8,
  parameter int PRESS_CYCLES = 5,
  parameter int CNT_W        = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             EvacSw,
  input  logic             PressSw,
  input  logic             PortOpen,
  output logic             EVState,
  output logic             Pressurized,
  output logic             Busy,
  output logic             Hold,
  output logic [CNT_W-1:0] Progress,
  output logic [1:0]       StateDbg
);

  typedef enum logic [1:0] {
    S_PRESSURIZED  = 2'd0,
    S_EVACUATING   = 2'd1,
    S_EVACUATED    = 2'd2,
    S_PRESSURIZING = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] EVAC_LAST  = CNT_W'(EVAC_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic evac_sync1_q, evac_sync2_q, evac_prev_q;
  logic press_sync1_q, press_sync2_q, press_prev_q;
  logic evac_pulse, press_pulse;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_q, hold_d;

  // Two-flop synchronizers followed by a previous-value flop for edge detection.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      evac_sync1_q  <= 1'b0;
      evac_sync2_q  <= 1'b0;
      evac_prev_q   <= 1'b0;
      press_sync1_q <= 1'b0;
      press_sync2_q <= 1'b0;
      press_prev_q  <= 1'b0;
    end else begin
      evac_sync1_q  <= EvacSw;
      evac_sync2_q  <= evac_sync1_q;
      evac_prev_q   <= evac_sync2_q;
      press_sync1_q <= PressSw;
      press_sync2_q <= press_sync1_q;
      press_prev_q  <= press_sync2_q;
    end
  end

  assign evac_pulse  = evac_sync2_q & ~evac_prev_q;
  assign press_pulse = press_sync2_q & ~press_prev_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_PRESSURIZED;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = 1'b0;
    case (state_q)
      S_PRESSURIZED: begin
        if (evac_pulse && !PortOpen && !press_pulse) begin
          state_d = S_EVACUATING;
          cnt_d   = '0;
        end
      end
      S_EVACUATED: begin
        if (press_pulse && !PortOpen && !evac_pulse) begin
          state_d = S_PRESSURIZING;
          cnt_d   = '0;
        end
      end
      S_EVACUATING: begin
        // An open port freezes the dwell; terminal compare means cnt never wraps.
        if (PortOpen) begin
          hold_d = 1'b1;
        end else if (cnt_q == EVAC_LAST) begin
          state_d = S_EVACUATED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRESSURIZING: begin
        if (PortOpen) begin
          hold_d = 1'b1;
        end else if (cnt_q == PRESS_LAST) begin
          state_d = S_PRESSURIZED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_PRESSURIZED;
        cnt_d   = '0;
      end
    endcase
  end

  assign EVState     = (state_q == S_EVACUATED);
  assign Pressurized = (state_q == S_PRESSURIZED);
  assign Busy        = (state_q == S_EVACUATING) || (state_q == S_PRESSURIZING);
  assign Hold        = hold_q;
  assign Progress    = Busy ? cnt_q : '0;
  assign StateDbg    = state_q;

endmodule

// File: tb/tb_chamber_pressure_ctrl.sv
// Bench for chamber_pressure_ctrl: directed scenarios plus random switch traffic,
// checked cycle by cycle against a remaining-time model of the chamber.
module tb_chamber_pressure_ctrl;

  localparam int EVAC_CYCLES  = 8;
  localparam int PRESS_CYCLES = 5;
  localparam int CNT_W        = 8;
  localparam int W            = CNT_W + 4;

  localparam int M_ATM   = 0;
  localparam int M_EVAC  = 1;
  localparam int M_VAC   = 2;
  localparam int M_PRESS = 3;

  logic             Clock;
  logic             Reset;
  logic             EvacSw;
  logic             PressSw;
  logic             PortOpen;
  logic             EVState;
  logic             Pressurized;
  logic             Busy;
  logic             Hold;
  logic [CNT_W-1:0] Progress;
  logic [1:0]       StateDbg;

  chamber_pressure_ctrl #(
    .EVAC_CYCLES (EVAC_CYCLES),
    .PRESS_CYCLES(PRESS_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .EvacSw     (EvacSw),
    .PressSw    (PressSw),
    .PortOpen   (PortOpen),
    .EVState    (EVState),
    .Pressurized(Pressurized),
    .Busy       (Busy),
    .Hold       (Hold),
    .Progress   (Progress),
    .StateDbg   (StateDbg)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_compared = 0;
  int n_failed   = 0;

  // Model: operator intent as a chamber mode plus remaining active cycles
  int mode;
  int remaining;
  bit hold_m;
  bit evac_hist[$];
  bit press_hist[$];

  function automatic logic [W-1:0] pack_outputs(logic ev, logic pr, logic bz, logic hd,
                                                logic [CNT_W-1:0] pg);
    return {ev, pr, bz, hd, pg};
  endfunction

  function automatic logic [W-1:0] dut_outputs();
    return pack_outputs(EVState, Pressurized, Busy, Hold, Progress);
  endfunction

  task automatic model_reset();
    mode      = M_ATM;
    remaining = 0;
    hold_m    = 1'b0;
    evac_hist  = '{1'b0, 1'b0, 1'b0};
    press_hist = '{1'b0, 1'b0, 1'b0};
  endtask

  function automatic logic [W-1:0] model_expected();
    int total;
    logic bz;
    logic [CNT_W-1:0] pg;
    total = (mode == M_EVAC) ? EVAC_CYCLES : PRESS_CYCLES;
    bz    = (mode == M_EVAC) || (mode == M_PRESS);
    pg    = bz ? CNT_W'(total - remaining) : '0;
    return pack_outputs(mode == M_VAC, mode == M_ATM, bz, hold_m, pg);
  endfunction

  // A switch level sampled at a clock edge becomes a request two edges later,
  // only if the level one edge before that was low.
  task automatic model_edge(input bit e, input bit p, input bit o);
    bit ep;
    bit pp;
    ep = evac_hist[1] && !evac_hist[0];
    pp = press_hist[1] && !press_hist[0];
    hold_m = 1'b0;
    case (mode)
      M_ATM: if (ep && !pp && !o) begin mode = M_EVAC; remaining = EVAC_CYCLES; end
      M_VAC: if (pp && !ep && !o) begin mode = M_PRESS; remaining = PRESS_CYCLES; end
      default: begin
        if (o) hold_m = 1'b1;
        else begin
          remaining--;
          if (remaining == 0) mode = (mode == M_EVAC) ? M_VAC : M_ATM;
        end
      end
    endcase
    evac_hist.push_back(e);
    press_hist.push_back(p);
    void'(evac_hist.pop_front());
    void'(press_hist.pop_front());
  endtask

  task automatic check_now(input string name, input logic [W-1:0] exp_v);
    logic [W-1:0] got;
    got = dut_outputs();
    n_compared++;
    if (got !== exp_v) begin
      n_failed++;
      $display("FAIL %s: got {ev,pr,busy,hold,prog}=%b_%0d required %b_%0d",
               name, got[W-1:CNT_W], got[CNT_W-1:0], exp_v[W-1:CNT_W], exp_v[CNT_W-1:0]);
    end
  endtask

  // Driver: apply inputs away from the edge, advance the model across the edge,
  // then queue the expected post-edge outputs.
  task automatic step(input bit e, input bit p, input bit o);
    EvacSw   = e;
    PressSw  = p;
    PortOpen = o;
    model_edge(e, p, o);
    @(posedge Clock);
    exp_q.push_back(model_expected());
    #2;
  endtask

  task automatic repeat_step(input int n, input bit e, input bit p, input bit o);
    for (int i = 0; i < n; i++) step(e, p, o);
  endtask

  // Monitor: compare on each falling edge whenever an expectation is pending.
  always @(negedge Clock) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] exp_v;
      exp_v = exp_q.pop_front();
      check_now("cycle_outputs", exp_v);
      if (EVState && Pressurized) begin
        n_failed++;
        $display("FAIL exclusive: got EVState=1 Pressurized=1 required not both");
      end
    end
  end

  localparam logic [W-1:0] RESET_EXP = {1'b0, 1'b1, 1'b0, 1'b0, {CNT_W{1'b0}}};

  initial begin
    Reset    = 1'b0;
    EvacSw   = 1'b0;
    PressSw  = 1'b0;
    PortOpen = 1'b0;
    model_reset();
    repeat (3) @(posedge Clock);
    #2;
    check_now("reset_state", RESET_EXP);
    Reset = 1'b1;

    // Evacuate, then pressurize with EvacSw still held high
    repeat_step(2, 0, 0, 0);
    repeat_step(12, 1, 0, 0);
    repeat_step(10, 1, 1, 0);
    repeat_step(3, 0, 0, 0);

    // Evacuate with a three-cycle pause at Progress=4, then pressurize
    repeat_step(7, 1, 0, 0);
    repeat_step(3, 1, 0, 1);
    repeat_step(6, 1, 0, 0);
    repeat_step(3, 0, 0, 0);
    repeat_step(10, 0, 1, 0);
    repeat_step(3, 0, 0, 0);

    // Request with port open, then simultaneous edges: both ignored
    repeat_step(5, 1, 0, 1);
    repeat_step(3, 0, 0, 0);
    repeat_step(5, 1, 1, 0);
    repeat_step(3, 0, 0, 0);

    // Press toggled mid-evac, evac held afterwards: no reversal, no retrigger
    repeat_step(4, 1, 0, 0);
    repeat_step(2, 1, 1, 0);
    repeat_step(14, 1, 0, 0);

    // Pressurize back, re-request the held state, then reset mid-evac
    repeat_step(8, 0, 1, 0);
    repeat_step(3, 0, 0, 0);
    repeat_step(4, 0, 1, 0);
    repeat_step(5, 1, 0, 0);
    @(negedge Clock);
    #1;
    Reset   = 1'b0;
    EvacSw  = 1'b0;
    PressSw = 1'b0;
    #1;
    check_now("async_reset_midrun", RESET_EXP);
    model_reset();
    @(posedge Clock);
    @(posedge Clock);
    #2;
    check_now("reset_held", RESET_EXP);
    Reset = 1'b1;

    // Random switch traffic with occasional port openings
    begin
      bit e;
      bit p;
      bit o;
      e = 1'b0;
      p = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 5) == 0) e = ~e;
        if ($urandom_range(0, 5) == 0) p = ~p;
        o = ($urandom_range(0, 9) == 0);
        step(e, p, o);
      end
    end

    @(negedge Clock);
    #1;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
